// File: rtl/exe_div_unit.sv
// Iterative 32-bit signed/unsigned divider for div.w/div.wu/mod.w/mod.wu with valid/ready handshakes.
// Optional build macro DIV_RADIX4_EN retires two quotient bits per cycle instead of one.
module exe_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_in_valid,
    output logic        div_in_ready,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_flush,
    output logic        div_out_valid,
    input  logic        div_out_ready,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder,
    output logic        div_busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

`ifdef DIV_RADIX4_EN
    localparam logic [5:0] LAST_STEP = 6'd15;
`else
    localparam logic [5:0] LAST_STEP = 6'd31;
`endif

    state_t      r_state, w_state_nxt;
    logic        r_vld;
    logic [31:0] r_rem, r_quo, r_dvs;
    logic [5:0]  r_cnt;
    logic        r_neg_q, r_neg_r;

    logic        w_accept, w_div0, w_s1_neg, w_s2_neg, w_last;
    logic [31:0] w_abs1, w_abs2, w_q_fix, w_r_fix;
    logic [63:0] w_step1, w_iter;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits. Returns {remainder, quotient shreg}.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] sh;
        logic [32:0] diff;
        sh   = {rem, quo[31]};
        diff = sh - {1'b0, dvs};
        if (!diff[32])
            return {diff[31:0], quo[30:0], 1'b1};
        else
            return {rem[30:0], quo[31], quo[30:0], 1'b0};
    endfunction

    assign w_accept = div_in_valid & div_in_ready;
    assign w_div0   = (div_src2 == 32'd0);
    assign w_s1_neg = div_signed & div_src1[31];
    assign w_s2_neg = div_signed & div_src2[31];
    assign w_abs1   = w_s1_neg ? (~div_src1 + 32'd1) : div_src1;
    assign w_abs2   = w_s2_neg ? (~div_src2 + 32'd1) : div_src2;
    assign w_last   = (r_cnt == LAST_STEP);

    assign w_step1 = div_step(r_rem, r_quo, r_dvs);
`ifdef DIV_RADIX4_EN
    logic [63:0] w_step2;
    assign w_step2 = div_step(w_step1[63:32], w_step1[31:0], r_dvs);
    assign w_iter  = w_step2;
`else
    assign w_iter  = w_step1;
`endif

    // Sign fix-up is folded into the final iteration so the result lands with DONE.
    assign w_q_fix = r_neg_q ? (~w_iter[31:0]  + 32'd1) : w_iter[31:0];
    assign w_r_fix = r_neg_r ? (~w_iter[63:32] + 32'd1) : w_iter[63:32];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_div0 ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (r_vld & div_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (div_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_vld         <= 1'b0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Valid trails entry into DONE by one cycle and drops on handshake or flush.
            r_vld   <= (r_state == S_DONE) & (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_rem   <= '0;
                r_quo   <= w_abs1;
                r_dvs   <= w_abs2;
                r_cnt   <= '0;
                r_neg_q <= w_s1_neg ^ w_s2_neg;
                r_neg_r <= w_s1_neg;
                if (w_div0) begin
                    div_quotient  <= 32'hFFFF_FFFF;
                    div_remainder <= div_src1;
                end
            end else if (r_state == S_CALC && !div_flush) begin
                r_rem <= w_iter[63:32];
                r_quo <= w_iter[31:0];
                r_cnt <= r_cnt + 6'd1;
                if (w_last) begin
                    div_quotient  <= w_q_fix;
                    div_remainder <= w_r_fix;
                end
            end
        end
    end

    assign div_in_ready  = (r_state == S_IDLE) & ~div_flush & ~reset;
    assign div_busy      = (r_state != S_IDLE);
    assign div_out_valid = r_vld;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed self-checking bench for exe_div_unit: results, latency, backpressure, flush, reset.
module tb_exe_div_unit;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_in_valid = 1'b0;
    logic        div_in_ready;
    logic        div_signed = 1'b0;
    logic [31:0] div_src1 = '0;
    logic [31:0] div_src2 = '0;
    logic        div_flush = 1'b0;
    logic        div_out_valid;
    logic        div_out_ready = 1'b0;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_busy;

    int n_tests = 0;
    int n_fail  = 0;

    exe_div_unit dut (
        .clk          (clk),
        .reset        (reset),
        .div_in_valid (div_in_valid),
        .div_in_ready (div_in_ready),
        .div_signed   (div_signed),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_flush    (div_flush),
        .div_out_valid(div_out_valid),
        .div_out_ready(div_out_ready),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Presents one request; returns #1 after the accept edge T0.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_pre", {31'b0, div_in_ready}, 32'd1);
        div_in_valid = 1'b1;
        div_signed   = sg;
        div_src1     = a;
        div_src2     = b;
        @(posedge clk); #1;
        div_in_valid = 1'b0;
    endtask

    // Counts edges after T0 until out_valid is seen, bounded.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!div_out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    task automatic handshake();
        @(negedge clk);
        div_out_ready = 1'b1;
        @(posedge clk); #1;
        div_out_ready = 1'b0;
        chk("hs_valid", {31'b0, div_out_valid}, 32'd0);
        chk("hs_in_ready", {31'b0, div_in_ready}, 32'd1);
        chk("hs_busy", {31'b0, div_busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] q, input logic [31:0] r);
        issue(sg, a, b);
        wait_valid({tag, "_lat"}, lat);
        chk({tag, "_q"}, div_quotient, q);
        chk({tag, "_r"}, div_remainder, r);
        handshake();
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'b0, div_in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, div_busy}, 32'd0);
        chk("rst_valid", {31'b0, div_out_valid}, 32'd0);
        chk("rst_q", div_quotient, 32'd0);
        chk("rst_r", div_remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, div_in_ready}, 32'd1);

        run_op("u100_7",   1'b0, 32'd100,        32'd7,          LAT, 32'd14,         32'd2);
        run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          LAT, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  LAT, 32'h8000_0000,  32'd0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          LAT, 32'hFFFF_FFFF,  32'd0);
        run_op("s_div0",   1'b1, 32'd5,          32'd0,          1,   32'hFFFF_FFFF,  32'd5);
        run_op("u_div0",   1'b0, 32'd5,          32'd0,          1,   32'hFFFF_FFFF,  32'd5);
        run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C,  32'd7,          LAT, 32'hFFFF_FFF2,  32'hFFFF_FFFE);

        // Backpressure: result and handshake state frozen while ready is low.
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_valid("bp_lat", LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, div_out_valid}, 32'd1);
            chk("bp_q", div_quotient, 32'hFFFF_FFFD);
            chk("bp_r", div_remainder, 32'hFFFF_FFFF);
            chk("bp_in_ready", {31'b0, div_in_ready}, 32'd0);
        end
        handshake();

        // Flush mid-CALC with a competing request in the same cycle.
        issue(1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            chk("fl_no_valid", {31'b0, div_out_valid}, 32'd0);
        end
        @(negedge clk);
        div_flush    = 1'b1;
        div_in_valid = 1'b1;
        div_signed   = 1'b0;
        div_src1     = 32'd9;
        div_src2     = 32'd3;
        #1;
        chk("fl_in_ready", {31'b0, div_in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("fl_busy", {31'b0, div_busy}, 32'd0);
        chk("fl_valid", {31'b0, div_out_valid}, 32'd0);
        @(negedge clk);
        div_flush = 1'b0;
        #1;
        chk("fl_in_ready_after", {31'b0, div_in_ready}, 32'd1);
        @(posedge clk); #1;
        div_in_valid = 1'b0;
        chk("fl_new_busy", {31'b0, div_busy}, 32'd1);
        wait_valid("fl_new_lat", LAT);
        chk("fl_new_q", div_quotient, 32'd3);
        chk("fl_new_r", div_remainder, 32'd0);
        handshake();

        // Flush in DONE with ready high discards the result.
        issue(1'b0, 32'd50, 32'd5);
        wait_valid("fd_lat", LAT);
        @(negedge clk);
        div_flush     = 1'b1;
        div_out_ready = 1'b1;
        @(posedge clk); #1;
        div_flush     = 1'b0;
        div_out_ready = 1'b0;
        chk("fd_valid", {31'b0, div_out_valid}, 32'd0);
        chk("fd_busy", {31'b0, div_busy}, 32'd0);

        // Reset during CALC.
        issue(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mr_in_ready", {31'b0, div_in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("mr_busy", {31'b0, div_busy}, 32'd0);
        chk("mr_valid", {31'b0, div_out_valid}, 32'd0);
        chk("mr_q", div_quotient, 32'd0);
        chk("mr_r", div_remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mr_no_stale", {31'b0, div_out_valid}, 32'd0);
        end
        run_op("mr_next", 1'b0, 32'd1000, 32'd3, LAT, 32'd333, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
